// File: rtl/p_flags_unit.sv
// p_flags_unit: 6502-style processor status register (N V - B D I Z C).
// Holds the six architectural flags and the interrupt mask that the
// interrupt arbiter samples at instruction boundaries. It also produces the
// carry-in and decimal-adjust controls for the ALU.
// Optional feature macro: CMOS_DEC_CLEAR_EN. When it is defined, interrupt
// entry also clears D (65C02). When it is undefined, D is left unchanged (NMOS).
module p_flags_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       alu_y7,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [7:0] db_in,
  input  logic       ld_nz,
  input  logic       ld_c,
  input  logic       ld_v,
  input  logic       ld_bit,
  input  logic       ld_p_db,
  input  logic [2:0] flag_op,
  input  logic       int_entry,
  input  logic       hw_int,
  input  logic       alu_sub,
  output logic [7:0] p_out,
  output logic       c_out,
  output logic       dec_add,
  output logic       dec_sub,
  output logic       irq_mask
);

  localparam logic [2:0] OP_CLC = 3'b001;
  localparam logic [2:0] OP_SEC = 3'b010;
  localparam logic [2:0] OP_CLI = 3'b011;
  localparam logic [2:0] OP_SEI = 3'b100;
  localparam logic [2:0] OP_CLD = 3'b101;
  localparam logic [2:0] OP_SED = 3'b110;
  localparam logic [2:0] OP_CLV = 3'b111;

  logic n_q, v_q, d_q, i_q, z_q, c_q, mask_q;
  logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx, mask_nx;

  // Bits 5:4 of a pulled status byte have no storage behind them.
  logic unused_db;
  assign unused_db = ^db_in[5:4];

  // Next-flag selection: int_entry > ld_p_db > ALU/BIT loads > flag_op.
  always_comb begin
    n_nx = n_q;
    v_nx = v_q;
    d_nx = d_q;
    i_nx = i_q;
    z_nx = z_q;
    c_nx = c_q;
    if (int_entry) begin
      i_nx = 1'b1;
`ifdef CMOS_DEC_CLEAR_EN
      d_nx = 1'b0;
`else
      d_nx = d_q;
`endif
    end else if (ld_p_db) begin
      n_nx = db_in[7];
      v_nx = db_in[6];
      d_nx = db_in[3];
      i_nx = db_in[2];
      z_nx = db_in[1];
      c_nx = db_in[0];
    end else begin
      if (ld_nz) begin
        n_nx = alu_y7;
        z_nx = alu_z;
      end
      if (ld_c) c_nx = alu_c;
      if (ld_v) v_nx = alu_v;
      // BIT operand bits take N and V even when the ALU also loads N,Z.
      if (ld_bit) begin
        n_nx = db_in[7];
        v_nx = db_in[6];
      end
      // A flag op yields to any same-cycle load of its own flag.
      case (flag_op)
        OP_CLC:  if (!ld_c) c_nx = 1'b0;
        OP_SEC:  if (!ld_c) c_nx = 1'b1;
        OP_CLI:  i_nx = 1'b0;
        OP_SEI:  i_nx = 1'b1;
        OP_CLD:  d_nx = 1'b0;
        OP_SED:  d_nx = 1'b1;
        OP_CLV:  if (!(ld_v || ld_bit)) v_nx = 1'b0;
        default: ;
      endcase
    end
  end

  // The mask samples the registered I at instruction boundaries. A change to I
  // in the boundary cycle itself becomes visible at the next boundary.
  always_comb begin
    mask_nx = mask_q;
    if (int_entry) mask_nx = 1'b1;
    else if (sync) mask_nx = i_q;
  end

  // Flag and mask registers; reset overrides every load in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      d_q    <= 1'b0;
      i_q    <= 1'b1;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      mask_q <= 1'b1;
    end else begin
      n_q    <= n_nx;
      v_q    <= v_nx;
      d_q    <= d_nx;
      i_q    <= i_nx;
      z_q    <= z_nx;
      c_q    <= c_nx;
      mask_q <= mask_nx;
    end
  end

  // Status byte view: bit 5 is always 1, and B reflects the push source.
  always_comb begin
    p_out = {n_q, v_q, 1'b1, ~hw_int, d_q, i_q, z_q, c_q};
  end

  assign c_out    = c_q;
  assign dec_add  = d_q & ~alu_sub;
  assign dec_sub  = d_q & alu_sub;
  assign irq_mask = mask_q;

endmodule

// File: tb/tb_p_flags_unit.sv
// Directed bench for p_flags_unit. Expected outputs are queued when a step is
// driven, then popped and compared one cycle later, after the clock edge.
// The expected D after interrupt entry follows CMOS_DEC_CLEAR_EN.
module tb_p_flags_unit;

  logic       clk = 1'b0;
  logic       reset, sync, alu_y7, alu_z, alu_c, alu_v;
  logic [7:0] db_in;
  logic       ld_nz, ld_c, ld_v, ld_bit, ld_p_db;
  logic [2:0] flag_op;
  logic       int_entry, hw_int, alu_sub;
  logic [7:0] p_out;
  logic       c_out, dec_add, dec_sub, irq_mask;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [7:0] p;
    logic       c;
    logic       dadd;
    logic       dsub;
    logic       mask;
  } exp_t;

  exp_t exp_q[$];

`ifdef CMOS_DEC_CLEAR_EN
  localparam logic D_AFTER_INT = 1'b0;
`else
  localparam logic D_AFTER_INT = 1'b1;
`endif

  p_flags_unit dut (
    .clk(clk), .reset(reset), .sync(sync),
    .alu_y7(alu_y7), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .db_in(db_in), .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v),
    .ld_bit(ld_bit), .ld_p_db(ld_p_db), .flag_op(flag_op),
    .int_entry(int_entry), .hw_int(hw_int), .alu_sub(alu_sub),
    .p_out(p_out), .c_out(c_out), .dec_add(dec_add), .dec_sub(dec_sub),
    .irq_mask(irq_mask)
  );

  always #5 clk = ~clk;

  // Return pulse-type controls to idle. hw_int, alu_sub and reset are left alone.
  task automatic idle();
    sync = 1'b0; alu_y7 = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    db_in = 8'h00; ld_nz = 1'b0; ld_c = 1'b0; ld_v = 1'b0; ld_bit = 1'b0;
    ld_p_db = 1'b0; flag_op = 3'b000; int_entry = 1'b0;
  endtask

  // Queue the expected result, clock once, then pop and compare after the edge.
  task automatic step(input string tag, input logic [7:0] p, input logic c,
                      input logic dadd, input logic dsub, input logic mask);
    exp_t e;
    exp_t got;
    e.tag = tag; e.p = p; e.c = c; e.dadd = dadd; e.dsub = dsub; e.mask = mask;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    compared++;
    assert (p_out === got.p) else begin
      mismatched++;
      $error("FAIL %s p_out observed=%h expected=%h", got.tag, p_out, got.p);
    end
    compared++;
    assert (c_out === got.c) else begin
      mismatched++;
      $error("FAIL %s c_out observed=%b expected=%b", got.tag, c_out, got.c);
    end
    compared++;
    assert (dec_add === got.dadd) else begin
      mismatched++;
      $error("FAIL %s dec_add observed=%b expected=%b", got.tag, dec_add, got.dadd);
    end
    compared++;
    assert (dec_sub === got.dsub) else begin
      mismatched++;
      $error("FAIL %s dec_sub observed=%b expected=%b", got.tag, dec_sub, got.dsub);
    end
    compared++;
    assert (irq_mask === got.mask) else begin
      mismatched++;
      $error("FAIL %s irq_mask observed=%b expected=%b", got.tag, irq_mask, got.mask);
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1; hw_int = 1'b0; alu_sub = 1'b0;
    step("reset", 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    sync = 1'b1;
    step("first_sync", 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);

    flag_op = 3'b110;
    step("sed", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    alu_sub = 1'b1;
    step("dec_sub", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    alu_sub = 1'b0;
    step("dec_add", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    flag_op = 3'b101;
    step("cld", 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);

    // CLI in a boundary cycle: I drops now, but the mask keeps the old I.
    flag_op = 3'b011; sync = 1'b1;
    step("cli_sync1", 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    step("cli_gap", 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    sync = 1'b1;
    step("cli_sync2", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    hw_int = 1'b1;
    ld_p_db = 1'b1; db_in = 8'hFF;
    step("plp_ff", 8'hEF, 1'b1, 1'b1, 1'b0, 1'b0);
    ld_nz = 1'b1; alu_y7 = 1'b0; alu_z = 1'b1;
    step("ld_nz", 8'h6F, 1'b1, 1'b1, 1'b0, 1'b0);
    flag_op = 3'b001;
    step("clc", 8'h6E, 1'b0, 1'b1, 1'b0, 1'b0);
    ld_c = 1'b1; alu_c = 1'b1; flag_op = 3'b001;
    step("ldc_over_clc", 8'h6F, 1'b1, 1'b1, 1'b0, 1'b0);
    flag_op = 3'b111;
    step("clv", 8'h2F, 1'b1, 1'b1, 1'b0, 1'b0);
    ld_bit = 1'b1; db_in = 8'h40; ld_nz = 1'b1; alu_y7 = 1'b1; alu_z = 1'b0;
    flag_op = 3'b111;
    step("bit_nz", 8'h6D, 1'b1, 1'b1, 1'b0, 1'b0);

    ld_p_db = 1'b1; db_in = 8'h30; ld_nz = 1'b1; alu_y7 = 1'b1; alu_z = 1'b1;
    ld_c = 1'b1; alu_c = 1'b1; flag_op = 3'b010;
    step("plp_prio", 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    flag_op = 3'b110;
    step("sed2", 8'h28, 1'b0, 1'b1, 1'b0, 1'b0);

    int_entry = 1'b1; ld_p_db = 1'b1; db_in = 8'hC3; ld_c = 1'b1; alu_c = 1'b1;
    flag_op = 3'b001;
    step("int_entry", {4'h2, D_AFTER_INT, 3'b100}, 1'b0, D_AFTER_INT, 1'b0, 1'b1);

    // Reset during an instruction overrides every load in that cycle.
    reset = 1'b1; ld_p_db = 1'b1; db_in = 8'hFF; ld_nz = 1'b1; alu_y7 = 1'b1;
    flag_op = 3'b110;
    step("reset_mid", 8'h24, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0; hw_int = 1'b0; sync = 1'b1;
    step("post_reset_sync", 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);

    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
